// File: rtl/err_collector.sv
// Error collector: sticky per-source error flags, first-failing index capture,
// new-episode irq pulse and a clear handshake. Optional macro ERR_COLLECTOR_CNT_EN adds cnt_o.
module err_collector #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] err_i,
    input  logic               clr_req_i,
    output logic               clr_ack_o,
    output logic [NUM_SRC-1:0] sticky_o,
    output logic [IDX_W-1:0]   first_idx_o,
    output logic               first_vld_o,
    output logic               irq_o,
    (* tmrx_error_sink *)
    output logic               err_o,
`ifdef ERR_COLLECTOR_CNT_EN
    output logic [CNT_W-1:0]   cnt_o,
`endif
    output logic [1:0]         dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_CLEAR = 2'b10;

    // Clear handshake: the requester holds clr_req_i high until it sees
    // clr_ack_o, which is high for exactly the one cycle spent in CLEAR.

    logic [1:0]         state_q, state_d;
    logic [NUM_SRC-1:0] sticky_q, sticky_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vld_q, vld_d;
    logic               irq_q, irq_d;
    logic               any_err;
    logic [IDX_W-1:0]   low_idx;

    assign any_err = |err_i;

    // Scan high-to-low so the lowest set index wins.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (err_i[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        sticky_d = sticky_q;
        idx_d    = idx_q;
        vld_d    = vld_q;
        irq_d    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                // Wipe captured state, then treat this cycle's errors as if in IDLE.
                sticky_d = err_i;
                vld_d    = any_err;
                idx_d    = any_err ? low_idx : '0;
                irq_d    = any_err;
                state_d  = any_err ? ST_ERR : ST_IDLE;
            end
            ST_ERR: begin
                sticky_d = sticky_q | err_i;
                if (clr_req_i) state_d = ST_CLEAR;
            end
            default: begin
                sticky_d = sticky_q | err_i;
                if (any_err) begin
                    vld_d = 1'b1;
                    idx_d = low_idx;
                end
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                end else if (any_err) begin
                    state_d = ST_ERR;
                    irq_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            sticky_q <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            idx_q    <= idx_d;
            vld_q    <= vld_d;
            irq_q    <= irq_d;
        end
    end

`ifdef ERR_COLLECTOR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts cycles with any error, not individual sources; saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = any_err ? CNT_W'(1) : '0;
        end else if (any_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
`endif

    assign clr_ack_o   = (state_q == ST_CLEAR);
    assign sticky_o    = sticky_q;
    assign first_idx_o = idx_q;
    assign first_vld_o = vld_q;
    assign irq_o       = irq_q;
    assign err_o       = |sticky_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/err_collector.md
ERR_COLLECTOR -- requirements
Module: err_collector

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, number of error sources (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, error-cycle counter width (2..16).
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port err_i  input  NUM_SRC  error flags from submodule error sinks, one per source, level-sampled each cycle.
REQ-006 The block SHALL have port clr_req_i  input  1  clear request, held high until clr_ack_o.
REQ-007 The block SHALL have port clr_ack_o  output  1  one-cycle clear acknowledge.
REQ-008 The block SHALL have port sticky_o  output  NUM_SRC  per-source sticky error flags.
REQ-009 The block SHALL have port first_idx_o  output  clog2(NUM_SRC) (min 1)  index of first-failing source.
REQ-010 The block SHALL have port first_vld_o  output  1  first_idx_o is valid.
REQ-011 The block SHALL have port irq_o  output  1  one-cycle pulse on new error episode.
REQ-012 The block SHALL have port err_o  output  1  OR of sticky_o; carries the tmrx_error_sink attribute.
REQ-013 The block SHALL have port cnt_o  output  CNT_W  saturating error-cycle count (present only with REQ-030 macro).

Function
REQ-014 The FSM SHALL have states IDLE (no sticky bit), ERR (some sticky bit set), CLEAR (one-cycle clear).
REQ-015 IDLE -> ERR SHALL occur on the edge where any err_i bit is 1; irq_o SHALL be 1 for exactly the following cycle.
REQ-016 sticky_o[i] SHALL be set on the first edge where err_i[i]=1 and hold until CLEAR (latency 1 cycle).
REQ-017 On IDLE -> ERR, first_idx_o SHALL capture the lowest set index of err_i and first_vld_o SHALL go 1; neither changes while in ERR.
REQ-018 Further errors in ERR SHALL only set sticky bits and count; irq_o SHALL stay 0.
REQ-019 clr_req_i=1 in IDLE or ERR SHALL move to CLEAR on the next edge; clr_ack_o SHALL be 1 exactly while in CLEAR.
REQ-020 On the CLEAR -> next edge, sticky_o, first_vld_o, first_idx_o, cnt_o SHALL be cleared and then err_i of that same cycle SHALL be applied as in IDLE (next state ERR with irq_o pulse if any err_i bit is 1, else IDLE).
REQ-021 If clr_req_i is still 1 in the cycle after CLEAR, a new clear SHALL begin (no deadlock, no lost ack).
REQ-022 err_o SHALL be the combinational OR of sticky_o (registered source, no err_i path).

Reset
REQ-023 rst_i=1 SHALL asynchronously force IDLE, sticky_o=0, first_idx_o=0, first_vld_o=0, irq_o=0, clr_ack_o=0, cnt_o=0, err_o=0.
REQ-024 Reset asserted mid-CLEAR SHALL drop clr_ack_o immediately; requester re-requests after release.
REQ-025 The first edge after rst_i deassertion SHALL sample err_i normally.

Configuration
REQ-030 Macro ERR_COLLECTOR_CNT_EN defined: cnt_o present; increments by 1 per cycle with any err_i bit 1 (not per source); saturates at 2^CNT_W-1; cleared by CLEAR, restarting from 1 if err_i nonzero in the CLEAR cycle.
REQ-031 Macro undefined: cnt_o port and counter absent; all other behaviour identical.

Verification
REQ-040 Reset, err_i=0 for 10 cycles -> all outputs 0, state IDLE.
REQ-041 err_i=4'b0110 one cycle -> next cycle sticky_o=0110, first_idx_o=1, first_vld_o=1, irq_o=1 one cycle, err_o=1, cnt_o=1.
REQ-042 Then err_i=4'b1000 one cycle -> sticky_o=1110, first_idx_o=1, irq_o=0, cnt_o=2.
REQ-043 CNT_W=2, err_i=0001 held 6 cycles -> cnt_o 1,2,3,3,3,3.
REQ-044 In ERR, clr_req_i=1 with err_i=0100 in the CLEAR cycle -> clr_ack_o 1 cycle, then sticky_o=0100, first_idx_o=2, irq_o pulse, cnt_o=1.
REQ-045 rst_i pulsed during CLEAR -> clr_ack_o drops same cycle, all outputs 0.
